// File: rtl/lsu_ctrl.sv
// Load/store control: decodes funct3 to memory strobes, splits misaligned accesses into byte beats.
// Latency handshake->resp_valid: error 1, aligned 2, split N+1 cycles; req_ready only while IDLE (LSU_MISALIGN_TRAP_EN traps misaligned).
module lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_load_enb,
  output logic        mem_lb,
  output logic        mem_lh,
  output logic        mem_lw,
  output logic        mem_lbu,
  output logic        mem_lhu,
  output logic        mem_sb,
  output logic        mem_sh,
  output logic        mem_sw,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, acc, acc_nxt, acc_ext;
  logic [1:0]  byte_idx;

  logic [2:0]  req_size;
  logic [32:0] req_last;
  logic        req_illegal, req_oor, req_misal, req_fail, split_last;

  // Classification of the incoming request; only meaningful on a handshake.
  always_comb begin
    case (req_funct3[1:0])
      2'd0:    req_size = 3'd1;
      2'd1:    req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    req_illegal = req_store ? (req_funct3 > 3'd2)
                            : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
    req_last  = {1'b0, req_addr} + 33'(req_size) - 33'd1;
    req_oor   = req_last >= 33'(MEM_BYTES);
    req_misal = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    req_fail  = req_illegal || req_oor || req_misal;
`else
    req_fail  = req_illegal || req_oor;
`endif
  end

  assign split_last = (byte_idx == (funct3_q[1] ? 2'd3 : 2'd1));

  // Byte gathered this beat merged into the accumulator, then extended.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[{byte_idx, 3'b000} +: 8] = mem_rdata[7:0];
    case (funct3_q)
      3'd1:    acc_ext = {{16{acc_nxt[15]}}, acc_nxt[15:0]};
      3'd5:    acc_ext = {16'h0000, acc_nxt[15:0]};
      default: acc_ext = acc_nxt;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    mem_load_enb = 1'b0;
    mem_lb       = 1'b0;
    mem_lh       = 1'b0;
    mem_lw       = 1'b0;
    mem_lbu      = 1'b0;
    mem_lhu      = 1'b0;
    mem_sb       = 1'b0;
    mem_sh       = 1'b0;
    mem_sw       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_fail)       state_nxt = RESP;
          else if (req_misal) state_nxt = SPLIT;
          else                state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (store_q) begin
          mem_sb = (funct3_q == 3'd0);
          mem_sh = (funct3_q == 3'd1);
          mem_sw = (funct3_q == 3'd2);
        end else begin
          mem_load_enb = 1'b1;
          mem_lb  = (funct3_q == 3'd0);
          mem_lh  = (funct3_q == 3'd1);
          mem_lw  = (funct3_q == 3'd2);
          mem_lbu = (funct3_q == 3'd4);
          mem_lhu = (funct3_q == 3'd5);
        end
        state_nxt = RESP;
      end
      SPLIT: begin
        mem_addr = addr_q + 32'(byte_idx);
        if (store_q) begin
          mem_sb    = 1'b1;
          mem_wdata = {24'h0, wdata_q[{byte_idx, 3'b000} +: 8]};
        end else begin
          mem_lbu      = 1'b1;
          mem_load_enb = 1'b1;
        end
        if (split_last) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response registers change only on the edge that enters RESP, so they hold between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      store_q    <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      acc        <= 32'h0;
      byte_idx   <= 2'd0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            acc      <= 32'h0;
            byte_idx <= 2'd0;
            if (req_fail) begin
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end
          end
        end
        ACCESS: begin
          resp_err   <= 1'b0;
          resp_rdata <= store_q ? 32'h0 : mem_rdata;
        end
        SPLIT: begin
          byte_idx <= byte_idx + 2'd1;
          acc      <= acc_nxt;
          if (split_last) begin
            resp_err   <= 1'b0;
            resp_rdata <= store_q ? 32'h0 : acc_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array memory model plus an abstract reference of load/store results and timing.
module tb_lsu_ctrl;
  localparam int MEM_BYTES = 4096;
  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_load_enb, mem_lb, mem_lh, mem_lw, mem_lbu, mem_lhu, mem_sb, mem_sh, mem_sw;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_load_enb(mem_load_enb), .mem_lb(mem_lb), .mem_lh(mem_lh), .mem_lw(mem_lw),
    .mem_lbu(mem_lbu), .mem_lhu(mem_lhu), .mem_sb(mem_sb), .mem_sh(mem_sh), .mem_sw(mem_sw),
    .mem_rdata(mem_rdata)
  );

  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  logic       mem_clear;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] strb;
  int         wr_n;

  assign strb = {mem_load_enb, mem_lb, mem_lh, mem_lw, mem_lbu, mem_lhu, mem_sb, mem_sh, mem_sw};
  assign wr_n = mem_sw ? 4 : mem_sh ? 2 : mem_sb ? 1 : 0;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  function automatic logic in_range(input logic [31:0] a, input int k);
    return (64'(a) + 64'(k)) < 64'(MEM_BYTES);
  endfunction

  // Byte-addressed little-endian memory with sized, extending reads.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[AW'(i)] <= init_byte(i);
    end else begin
      for (int k = 0; k < 4; k++)
        if (k < wr_n && in_range(mem_addr, k)) mem[AW'(mem_addr + 32'(k))] <= mem_wdata[8*k +: 8];
    end
  end

  always_comb begin
    logic [31:0] raw;
    raw = 32'h0;
    for (int k = 0; k < 4; k++)
      if (in_range(mem_addr, k)) raw[8*k +: 8] = mem[AW'(mem_addr + 32'(k))];
    mem_rdata = 32'h0;
    if (mem_lw)       mem_rdata = raw;
    else if (mem_lh)  mem_rdata = {{16{raw[15]}}, raw[15:0]};
    else if (mem_lhu) mem_rdata = {16'h0, raw[15:0]};
    else if (mem_lb)  mem_rdata = {{24{raw[7]}}, raw[7:0]};
    else if (mem_lbu) mem_rdata = {24'h0, raw[7:0]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: architectural effect of one request, independent of how it is sequenced.
  task automatic ref_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic err, output logic [31:0] rd, output int lat, output int nacc);
    int sz;
    logic illegal, mis;
    logic [31:0] v;
    sz      = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = st ? (f3 > 3'd2) : (f3 inside {3'd3, 3'd6, 3'd7});
    mis     = (a % 32'(sz)) != 0;
    err     = illegal || !in_range(a, sz - 1);
`ifdef LSU_MISALIGN_TRAP_EN
    err = err || mis;
`endif
    rd = 32'h0;
    if (err) begin
      lat = 1; nacc = 0;
    end else begin
      lat  = mis ? sz + 1 : 2;
      nacc = mis ? sz : 1;
      if (st) begin
        for (int k = 0; k < sz; k++) ref_mem[AW'(a + 32'(k))] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_mem[AW'(a + 32'(k))];
        case (f3)
          3'd0:    rd = {{24{v[7]}}, v[7:0]};
          3'd1:    rd = {{16{v[15]}}, v[15:0]};
          3'd4:    rd = {24'h0, v[7:0]};
          3'd5:    rd = {16'h0, v[15:0]};
          default: rd = v;
        endcase
      end
    end
  endtask

  task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got_rd);
    logic e_err, multi, addr_bad;
    logic [31:0] e_rd;
    int e_lat, e_nacc, lat, nacc, guard;
    ref_op(st, f3, a, wd, e_err, e_rd, e_lat, e_nacc);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; nacc = 0; multi = 1'b0; addr_bad = 1'b0;
    while (!resp_valid && lat <= 8) begin
      if ($countones(strb[7:0]) > 1 || strb[8] != |strb[7:3]) multi = 1'b1;
      if (|strb[7:0]) begin
        if (mem_addr != a + 32'(nacc)) addr_bad = 1'b1;
        nacc++;
      end
      @(negedge clk);
      lat++;
    end
    got_rd = resp_rdata;
    check_eq({tag, "_lat"},    32'(lat),      32'(e_lat));
    check_eq({tag, "_err"},    32'(resp_err), 32'(e_err));
    check_eq({tag, "_rdata"},  resp_rdata,    e_rd);
    check_eq({tag, "_naccess"}, 32'(nacc),    32'(e_nacc));
    check_eq({tag, "_onehot"}, 32'(multi),    32'd0);
    check_eq({tag, "_addrseq"}, 32'(addr_bad), 32'd0);
    check_eq({tag, "_resp_strb"}, 32'(strb),  32'd0);
    @(negedge clk);
    check_eq({tag, "_pulse"},  32'(resp_valid), 32'd0);
    check_eq({tag, "_hold"},   resp_rdata,    e_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    logic st;
    logic [2:0] f3;
    int diffs, seen;
    rst = 1'b1; mem_clear = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[AW'(i)] = init_byte(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready),  32'd1);
    check_eq("rst_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_err",   32'(resp_err),   32'd0);
    check_eq("rst_rdata", resp_rdata,      32'd0);
    check_eq("rst_strb",  32'(strb),       32'd0);
    check_eq("rst_addr",  mem_addr,        32'd0);
    check_eq("rst_wdata", mem_wdata,       32'd0);
    rst = 1'b0; mem_clear = 1'b0;
    @(negedge clk);

    do_req("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd);
    do_req("lw10", 1'b0, 3'd2, 32'h10, 32'h0, rd);        check_eq("lw10_val", rd, 32'hDEADBEEF);
    do_req("lb13", 1'b0, 3'd0, 32'h13, 32'h0, rd);        check_eq("lb13_val", rd, 32'hFFFFFFDE);
    do_req("lbu13", 1'b0, 3'd4, 32'h13, 32'h0, rd);       check_eq("lbu13_val", rd, 32'h000000DE);
    do_req("lhu12", 1'b0, 3'd5, 32'h12, 32'h0, rd);       check_eq("lhu12_val", rd, 32'h0000DEAD);
    do_req("sw21", 1'b1, 3'd2, 32'h21, 32'h11223344, rd);
    do_req("lw21", 1'b0, 3'd2, 32'h21, 32'h0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
    check_eq("lw21_val", rd, 32'h11223344);
`endif
    do_req("sh41", 1'b1, 3'd1, 32'h41, 32'h00008001, rd);
    do_req("lh41", 1'b0, 3'd1, 32'h41, 32'h0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
    check_eq("lh41_val", rd, 32'hFFFF8001);
`endif
    do_req("ld_f3_3", 1'b0, 3'd3, 32'h0, 32'h0, rd);
    do_req("sw_top", 1'b1, 3'd2, 32'(MEM_BYTES - 2), 32'h12345678, rd);
    do_req("sb_last", 1'b1, 3'd0, 32'(MEM_BYTES - 1), 32'h000000A5, rd);
    do_req("lw_last", 1'b0, 3'd2, 32'(MEM_BYTES - 4), 32'h0, rd);
    do_req("lh_wrap", 1'b0, 3'd1, 32'hFFFFFFFF, 32'h0, rd);

`ifndef LSU_MISALIGN_TRAP_EN
    // Abort a split store after its second byte has been written.
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h61; req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("abort_b0_addr", mem_addr, 32'h61);
    @(negedge clk);
    check_eq("abort_b1_addr", mem_addr, 32'h62);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", 32'(req_ready),  32'd1);
    check_eq("abort_valid", 32'(resp_valid), 32'd0);
    check_eq("abort_strb",  32'(strb),       32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (resp_valid) seen++; end
    check_eq("abort_no_resp", 32'(seen), 32'd0);
    ref_mem[AW'(32'h61)] = 8'hDD;
    ref_mem[AW'(32'h62)] = 8'hCC;
    check_eq("abort_m61", 32'(mem[AW'(32'h61)]), 32'h000000DD);
    check_eq("abort_m62", 32'(mem[AW'(32'h62)]), 32'h000000CC);
    check_eq("abort_m63", 32'(mem[AW'(32'h63)]), 32'(init_byte(32'h63)));
`endif

    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = 32'(MEM_BYTES) - 32'($urandom_range(1, 6));
        1:       a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        2:       a = $urandom;
        default: a = 32'($urandom_range(0, 255));
      endcase
      do_req("rnd", st, f3, a, $urandom, rd);
    end

    diffs = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[AW'(i)] !== ref_mem[AW'(i)]) diffs++;
    check_eq("mem_image", 32'(diffs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage between the execute stage and the byte-addressed data memory.
- Accepts one RISC-V load/store request per handshake and decodes funct3 into the memory's one-hot strobes (sb/sh/sw, lb/lh/lw/lbu/lhu, load_enb).
- Splits misaligned accesses into byte sequences and returns a registered response with a valid pulse.

Parameters:
- MEM_BYTES, 4096: memory size in bytes. An access touching any byte at or above MEM_BYTES is an error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready
- req_store  input  1  1=store, 0=load
- req_funct3  input  3  RISC-V funct3
- req_addr  input  32  byte address
- req_wdata  input  32  store data, LSB-aligned
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  extended load data (0 for stores/errors)
- resp_err  output  1  illegal funct3, out of range, or trapped misalign
- mem_addr  output  32  memory byte address
- mem_wdata  output  32  memory store data
- mem_load_enb, mem_lb, mem_lh, mem_lw, mem_lbu, mem_lhu  output  1 each  load strobes
- mem_sb, mem_sh, mem_sw  output  1 each  store strobes
- mem_rdata  input  32  combinational memory read data

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE; req_ready=1 from the first cycle after reset. resp_valid=0, resp_err=0, resp_rdata=0. All mem strobes=0; mem_addr=0; mem_wdata=0.
- States: IDLE, ACCESS, SPLIT, RESP. req_ready=1 only in IDLE.
- IDLE, on handshake: register store, funct3, addr, wdata. Then classify:
  - Illegal: load funct3 in {3,6,7}, or store funct3 >2. Go to RESP with err.
  - Out of range: addr+size-1 >= MEM_BYTES, computed 33-bit so no wrap. Go to RESP with err.
  - Aligned: byte; half with addr[0]=0; word with addr[1:0]=0. Go to ACCESS.
  - Misaligned: go to SPLIT with byte_idx=0 and N=2 (half) or 4 (word).
- ACCESS (exactly 1 cycle):
  - mem_addr=addr; exactly one strobe set per funct3. For loads, mem_load_enb=1.
  - mem_wdata=wdata; the store commits at the end of this cycle.
  - Load: resp_rdata <= mem_rdata at the clock edge. Then go to RESP.
- SPLIT (N cycles):
  - Each cycle: mem_addr=addr+byte_idx (32-bit).
  - Store: mem_sb=1, mem_wdata[7:0]=wdata[8*byte_idx+:8].
  - Load: mem_lbu=1, mem_load_enb=1; acc[8*byte_idx+:8] <= mem_rdata[7:0].
  - byte_idx increments each cycle. After byte N-1, extend acc per funct3 (lh: sign from bit15; lhu: zero; lw: none) into resp_rdata. Go to RESP.
- RESP (1 cycle): resp_valid=1, resp_err as classified. resp_rdata=0 for stores and errors. Next state IDLE.
- Latency from handshake to resp_valid:
  - Aligned: 2 cycles.
  - Split: N+1 cycles.
  - Error: 1 cycle.
- Strobes: at most one strobe high per cycle. All strobes are 0 in IDLE and RESP. No memory access ever occurs on an error.
- Request handling: req_valid while not IDLE is ignored; the requester holds its request. resp_rdata/resp_err hold their values until the next RESP.
- rst mid-operation: IDLE on the next edge, strobes drop immediately. Bytes already written by a partial split store remain; no rollback. No response is issued for the aborted request.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned half/word requests are not split. They go directly to RESP with resp_err=1 and no memory access; SPLIT is unreachable.
- Undefined: misaligned accesses are split as described above.

Test Plan:
- Aligned store/load: store sw 0x10=0xDEADBEEF, then lw 0x10.
  - Store: resp_valid 2 cycles after handshake, err=0.
  - Load: resp_rdata=0xDEADBEEF 2 cycles after handshake.
- Byte/half extension: lb 0x13 -> 0xFFFFFFDE. lbu 0x13 -> 0x000000DE. lhu 0x12 -> 0x0000DEAD.
- Misaligned word: sw 0x21=0x11223344 shows 4 consecutive mem_sb cycles at addresses 0x21..0x24. Then lw 0x21 -> 0x11223344 with resp_valid 5 cycles after handshake.
- Misaligned half: sh 0x41=0x8001, then lh 0x41 -> 0xFFFF8001 after 3 cycles.
- Errors: load funct3=3 -> err=1, rdata=0, 1 cycle. sw at MEM_BYTES-2 -> err=1, no strobe observed. With LSU_MISALIGN_TRAP_EN: lw 0x21 -> err=1, no strobe.
- Reset mid-split: assert rst during byte_idx=1 of sw 0x61=0xAABBCCDD.
  - Next cycle: IDLE, no resp_valid, req_ready=1.
  - Memory then holds 0x61=0xDD and 0x62=0xCC only.
